// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types.
//   word_t      - 32-bit datapath word
//   aluop_t     - ALU operation encoding carried on alu_if.aluop
//   multstate_t - state of the iterative multiplier (alu_mult_seq)
//   MULT_ITER   - multiplier iteration count (one per word bit)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {MS_IDLE, MS_RUN, MS_DONE} multstate_t;

    localparam int MULT_ITER = 32;

endpackage

// File: rtl/alu_if.sv
// alu_if: connection between an ALU requester and the datapath ALU.
//   portA, portB, aluop  - operands and operation, driven by the requester (tb modport)
//   result, neg, ovf, zero - combinational ALU response (alu modport)
interface alu_if;
    import cpu_types_pkg::*;

    word_t  portA;
    word_t  portB;
    aluop_t aluop;
    word_t  result;
    logic   neg;
    logic   ovf;
    logic   zero;

    modport tb  (output portA, portB, aluop, input result, neg, ovf, zero);
    modport alu (input portA, portB, aluop, output result, neg, ovf, zero);
endinterface

// File: rtl/alu.sv
// alu: combinational datapath ALU sitting behind alu_if.alu.
//   a.portA/a.portB/a.aluop in; a.result, a.neg (result sign), a.zero,
//   a.ovf (signed overflow for ADD/SUB) out. No carry flag is exposed.
module alu
    import cpu_types_pkg::*;
(
    alu_if.alu a
);
    word_t res;

    always_comb begin
        res = '0;
        case (a.aluop)
            ALU_SLL:  res = a.portA << a.portB[4:0];
            ALU_SRL:  res = a.portA >> a.portB[4:0];
            ALU_ADD:  res = a.portA + a.portB;
            ALU_SUB:  res = a.portA - a.portB;
            ALU_AND:  res = a.portA & a.portB;
            ALU_OR:   res = a.portA | a.portB;
            ALU_XOR:  res = a.portA ^ a.portB;
            ALU_NOR:  res = ~(a.portA | a.portB);
            ALU_SLT:  res = {31'b0, $signed(a.portA) < $signed(a.portB)};
            ALU_SLTU: res = {31'b0, a.portA < a.portB};
            default:  res = '0;
        endcase
    end

    always_comb begin
        a.result = res;
        a.neg    = res[31];
        a.zero   = (res == '0);
        a.ovf    = 1'b0;
        if (a.aluop == ALU_ADD)
            a.ovf = (a.portA[31] == a.portB[31]) && (res[31] != a.portA[31]);
        else if (a.aluop == ALU_SUB)
            a.ovf = (a.portA[31] != a.portB[31]) && (res[31] != a.portA[31]);
    end
endmodule

// File: rtl/alu_mult_seq_carry_gen.sv
// alu_carry_gen: recovers the unsigned carry-out of A+B from the operand
// and result sign bits, since the ALU exposes no carry flag.
//   a, b   - adder operands
//   result - 32-bit sum from the ALU
//   carry  - carry out of bit 31
module alu_carry_gen
    import cpu_types_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t result,
    output logic  carry
);
    // Both tops set -> carry; exactly one set -> carry iff the sum top bit cleared.
    assign carry = (a[31] & b[31]) | ((a[31] ^ b[31]) & ~result[31]);
endmodule

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: iterative 32x32->64 unsigned shift-add multiplier that
// borrows the datapath ALU for its additions.
//   CLK, RST        - clock, asynchronous active-high reset
//   start           - request, sampled only when idle
//   mcand, mplier   - operands, latched on accept
//   busy            - high while running or presenting the result
//   done            - one-cycle pulse; prod_hi/prod_lo valid
//   prod_hi/prod_lo - product, held until the next completion
//   alu             - requester side of alu_if; driven only while running
module alu_mult_seq
    import cpu_types_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0,
    parameter int ITER       = MULT_ITER
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    input  word_t mcand,
    input  word_t mplier,
    output logic  busy,
    output logic  done,
    output word_t prod_hi,
    output word_t prod_lo,
    alu_if.tb     alu
);
    localparam int CW = $clog2(ITER);

    multstate_t   state_q, state_d;
    word_t        hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
    word_t        prod_hi_q, prod_hi_d, prod_lo_q, prod_lo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    word_t        op_a, op_b, hi_n, lo_n, rem_mask;
    logic         carry;
    logic [CW-1:0] rem;
    logic [63:0]  aligned;
    logic         unused_flags;

    // ALU operands are kept separate from the state logic so the
    // ALU result feeds back without an apparent combinational loop.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state_q == MS_RUN) begin
            op_a = hi_q;
            op_b = lo_q[0] ? mc_q : '0;
        end
    end

    assign alu.portA = op_a;
    assign alu.portB = op_b;
    assign alu.aluop = ALU_ADD;
    assign unused_flags = ^{alu.neg, alu.ovf, alu.zero};

    alu_carry_gen u_carry (
        .a      (op_a),
        .b      (op_b),
        .result (alu.result),
        .carry  (carry)
    );

    assign hi_n = {carry, alu.result[31:1]};
    assign lo_n = {alu.result[0], lo_q[31:1]};

    // Unconsumed multiplier bits sit right-aligned in lo_n. If they are all
    // zero, the remaining iterations would only shift {hi,lo} right.
    assign rem      = CW'(ITER - 1) - cnt_q;
    assign rem_mask = (word_t'(1) << rem) - word_t'(1);
    assign aligned  = {hi_n, lo_n} >> rem;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mc_d      = mc_q;
        cnt_d     = cnt_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        case (state_q)
            MS_IDLE: begin
                if (start) begin
                    mc_d    = mcand;
                    hi_d    = '0;
                    lo_d    = mplier;
                    cnt_d   = '0;
                    state_d = MS_RUN;
                end
            end
            MS_RUN: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d   = MS_DONE;
                    prod_hi_d = hi_n;
                    prod_lo_d = lo_n;
                end else if (EARLY_EXIT && ((lo_n & rem_mask) == '0)) begin
                    state_d   = MS_DONE;
                    {hi_d, lo_d} = aligned;
                    {prod_hi_d, prod_lo_d} = aligned;
                end
            end
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= MS_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mc_q      <= '0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mc_q      <= mc_d;
            cnt_q     <= cnt_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    assign busy    = (state_q != MS_IDLE);
    assign done    = (state_q == MS_DONE);
    assign prod_hi = prod_hi_q;
    assign prod_lo = prod_lo_q;
endmodule
